// File: rtl/serial_add_compare.sv
// Bit-serial adder/comparator: shifts two latched operands LSB first through one
// full adder, producing x+y (with final carry) and an x==y flag in the same pass.
module serial_add_compare #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum,
    output logic             equal
);

    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             eq_q, eq_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             equal_q, equal_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full adder built from two half adders plus the carry OR.
    logic ha1_s, ha1_c, ha2_s, ha2_c, carry_nx;

    always_comb begin
        ha1_s    = a_q[0] ^ b_q[0];
        ha1_c    = a_q[0] & b_q[0];
        ha2_s    = ha1_s ^ carry_q;
        ha2_c    = ha1_s & carry_q;
        carry_nx = ha1_c | ha2_c;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        eq_d    = eq_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        equal_d = equal_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = x;
                    b_d     = y;
                    s_d     = '0;
                    carry_d = 1'b0;
                    eq_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // New sum bit enters at the top; the bit falling off the bottom is discarded.
                s_d     = WIDTH'({ha2_s, s_q} >> 1);
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_nx;
                eq_d    = eq_q & ~ha1_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {carry_nx, s_d};
                    equal_d = eq_d;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flags are registered from the next state so they line up with it.
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            equal_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            eq_q    <= eq_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            equal_q <= equal_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign equal = equal_q;

endmodule

// File: tb/tb_serial_add_compare.sv
// Bench for serial_add_compare: timeline model checked every cycle, plus
// directed operations with literal expected results.
module tb_serial_add_compare;

    localparam int W = 5;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x, y;
    logic         busy, done, equal;
    logic [W:0]   sum;

    int errors = 0;
    int checks = 0;

    serial_add_compare #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .equal (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: after an accepted start the op occupies W+1 cycles; the last one is the done cycle.
    int         m_rem;
    logic [W-1:0] m_x, m_y;
    logic [W:0] m_sum;
    logic       m_eq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0;
            m_sum = '0;
            m_eq  = 1'b0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_x   = x;
                m_y   = y;
                m_rem = W + 1;
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 1) begin
                m_sum = {1'b0, m_x} + {1'b0, m_y};
                m_eq  = (m_x == m_y);
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_busy",  {31'd0, busy},  {31'd0, (m_rem > 1)});
        check("cyc_done",  {31'd0, done},  {31'd0, (m_rem == 1)});
        check("cyc_sum",   {26'd0, sum},   {26'd0, m_sum});
        check("cyc_equal", {31'd0, equal}, {31'd0, m_eq});
    end

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] ya,
                          input logic [W:0] es, input logic ee, input string nm);
        int bc;
        bit found;
        bc = 0;
        found = 0;
        @(posedge clk);
        #1;
        x = xa;
        y = ya;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = ~xa;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                break;
            end
            if (busy) bc++;
        end
        check({nm, "_done_seen"}, {31'd0, found}, 32'd1);
        check({nm, "_sum"}, {26'd0, sum}, {26'd0, es});
        check({nm, "_equal"}, {31'd0, equal}, {31'd0, ee});
        check({nm, "_busy_cycles"}, bc, W);
        $display("op %s: x=%b y=%b sum=%b equal=%b busy_cycles=%0d", nm, xa, ya, sum, equal, bc);
    endtask

    initial begin
        int first_i, second_i;
        logic [W:0] first_sum;
        logic first_eq;

        rst_n = 1'b0;
        start = 1'b0;
        x = '0;
        y = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {26'd0, sum}, 32'd0);
        check("rst_equal", {31'd0, equal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(5'b00000, 5'b00000, 6'b000000, 1'b1, "zero");
        run_op(5'b00001, 5'b00001, 6'b000010, 1'b1, "one_one");
        run_op(5'b00001, 5'b00100, 6'b000101, 1'b0, "one_four");
        run_op(5'b10101, 5'b10100, 6'b101001, 1'b0, "21_20");
        run_op(5'b11100, 5'b00011, 6'b011111, 1'b0, "28_3");
        run_op(5'b11111, 5'b11111, 6'b111110, 1'b1, "max_max");
        run_op(5'b01100, 5'b01100, 6'b011000, 1'b1, "12_12");

        // start held high for 10 edges while operands change every cycle
        first_i = -1;
        second_i = -1;
        first_sum = '0;
        first_eq = 1'b1;
        @(posedge clk);
        #1;
        x = 5'b10101;
        y = 5'b00001;
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (i >= 9) start = 1'b0;
            x = W'($urandom);
            y = W'($urandom);
            @(negedge clk);
            if (done) begin
                if (first_i < 0) begin
                    first_i = i;
                    first_sum = sum;
                    first_eq = equal;
                end else if (second_i < 0) begin
                    second_i = i;
                end
            end
        end
        check("held_first_done_cycle", first_i, 5);
        check("held_second_done_cycle", second_i, 12);
        check("held_first_sum", {26'd0, first_sum}, 32'b010110);
        check("held_first_equal", {31'd0, first_eq}, 32'd0);
        $display("held start: done at cycles %0d and %0d, first sum=%b", first_i, second_i, first_sum);

        // asynchronous reset in the middle of SHIFT
        @(posedge clk);
        #1;
        x = 5'b11111;
        y = 5'b11110;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_sum", {26'd0, sum}, 32'd0);
        check("arst_equal", {31'd0, equal}, 32'd0);
        $display("async reset mid-shift: busy=%b done=%b sum=%b equal=%b", busy, done, sum, equal);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        run_op(5'b00111, 5'b00001, 6'b001000, 1'b0, "after_reset");

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
